// File: rtl/lvdc_timing_pkg.sv
// Shared types, default geometry and decode helpers for the LVDC timing generator.
// The one-hot decode is sized for the widest strobe bus and truncated at the call site.
package lvdc_timing_pkg;

  localparam int DEF_N_SUB    = 4;
  localparam int DEF_N_BITS   = 14;
  localparam int DEF_N_PHASES = 3;

  localparam int ONEHOT_MAX_W = 32;
  localparam int ONEHOT_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_HALTED    = 2'd0,
    ST_RUN       = 2'd1,
    ST_HALT_PEND = 2'd2,
    ST_STEP      = 2'd3
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [ONEHOT_IDX_W-1:0] idx);
    return {{(ONEHOT_MAX_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/lvdc_timing_gen_if.sv
// Control and strobe bundle between the timing generator (master) and its consumers (slave).
interface lvdc_timing_gen_if import lvdc_timing_pkg::*; #(
  parameter int N_SUB    = DEF_N_SUB,
  parameter int N_BITS   = DEF_N_BITS,
  parameter int N_PHASES = DEF_N_PHASES
) ();

  logic                run;
  logic                step;
  logic [N_SUB-1:0]    sb;
  logic [N_BITS-1:0]   bt;
  logic [N_PHASES-1:0] ph;
  logic                phase_end;
  logic                word_end;
  logic                halted;
  logic                step_ack;

  modport master (
    input  run,
    input  step,
    output sb,
    output bt,
    output ph,
    output phase_end,
    output word_end,
    output halted,
    output step_ack
  );

  modport slave (
    output run,
    output step,
    input  sb,
    input  bt,
    input  ph,
    input  phase_end,
    input  word_end,
    input  halted,
    input  step_ack
  );

endinterface

// File: rtl/lvdc_wrap_counter.sv
// Binary modulo-N counter; at_max flags the terminal count so counters can be chained.
module lvdc_wrap_counter import lvdc_timing_pkg::*; #(
  parameter  int N = 4,
  localparam int W = cnt_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max_s;

  assign at_max_s = (cnt_q == W'(N - 1));

  // Next count: increment when enabled, wrapping the terminal count back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (at_max_s) begin
        cnt_d = {W{1'b0}};
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign at_max = at_max_s;

endmodule

// File: rtl/lvdc_timing_gen.sv
// Master LVDC timing generator: sub-bit/bit/phase strobes plus a run/halt/step controller
// that only stops at word (run) or phase (step) boundaries.
module lvdc_timing_gen import lvdc_timing_pkg::*; #(
  parameter int N_SUB    = DEF_N_SUB,
  parameter int N_BITS   = DEF_N_BITS,
  parameter int N_PHASES = DEF_N_PHASES
) (
  input logic               clk,
  input logic               rst,
  lvdc_timing_gen_if.master bus
);

  localparam int SUB_W = cnt_width(N_SUB);
  localparam int BIT_W = cnt_width(N_BITS);
  localparam int PH_W  = cnt_width(N_PHASES);

  state_e              state_q, state_d;
  logic                step_q, step_d;
  logic [N_SUB-1:0]    sb_q, sb_d;
  logic [N_BITS-1:0]   bt_q, bt_d;
  logic [N_PHASES-1:0] ph_q, ph_d;
  logic                phase_end_q, phase_end_d;
  logic                word_end_q, word_end_d;
  logic                halted_q, halted_d;
  logic                step_ack_q, step_ack_d;

  logic [SUB_W-1:0]    sub_cnt_s;
  logic [BIT_W-1:0]    bit_cnt_s;
  logic [PH_W-1:0]     ph_cnt_s;
  logic                sub_max_s, bit_max_s, ph_max_s;
  logic                adv_s, bit_en_s, ph_en_s;
  logic                phase_bnd_s, word_bnd_s, step_rise_s;

  assign adv_s       = (state_q != ST_HALTED);
  assign bit_en_s    = adv_s & sub_max_s;
  assign ph_en_s     = bit_en_s & bit_max_s;
  assign phase_bnd_s = sub_max_s & bit_max_s;
  assign word_bnd_s  = phase_bnd_s & ph_max_s;
  assign step_rise_s = bus.step & ~step_q;

  lvdc_wrap_counter #(.N(N_SUB)) u_sub_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (adv_s),
    .cnt    (sub_cnt_s),
    .at_max (sub_max_s)
  );

  lvdc_wrap_counter #(.N(N_BITS)) u_bit_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (bit_en_s),
    .cnt    (bit_cnt_s),
    .at_max (bit_max_s)
  );

  lvdc_wrap_counter #(.N(N_PHASES)) u_ph_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (ph_en_s),
    .cnt    (ph_cnt_s),
    .at_max (ph_max_s)
  );

  // Run/halt/step controller; halting only happens on a boundary cycle, so no partial word escapes.
  always_comb begin
    state_d = state_q;
    step_d  = bus.step;
    case (state_q)
      ST_HALTED: begin
        if (bus.run) begin
          state_d = ST_RUN;
        end else if (step_rise_s) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_RUN: begin
        if (!bus.run) begin
          state_d = word_bnd_s ? ST_HALTED : ST_HALT_PEND;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT_PEND: begin
        // A returning run wins over the pending halt so the strobe train has no gap.
        if (bus.run) begin
          state_d = ST_RUN;
        end else if (word_bnd_s) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_HALT_PEND;
        end
      end
      ST_STEP: begin
        if (phase_bnd_s) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_STEP;
        end
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  // Output decode: bt/ph always track the counters, strobes and pulses only while advancing.
  always_comb begin
    sb_d        = {N_SUB{1'b0}};
    bt_d        = N_BITS'(onehot(ONEHOT_IDX_W'(bit_cnt_s)));
    ph_d        = N_PHASES'(onehot(ONEHOT_IDX_W'(ph_cnt_s)));
    phase_end_d = 1'b0;
    word_end_d  = 1'b0;
    step_ack_d  = 1'b0;
    halted_d    = ~adv_s;
    if (adv_s) begin
      sb_d        = N_SUB'(onehot(ONEHOT_IDX_W'(sub_cnt_s)));
      phase_end_d = phase_bnd_s;
      word_end_d  = word_bnd_s;
      step_ack_d  = (state_q == ST_STEP) & phase_bnd_s;
    end else begin
      sb_d        = {N_SUB{1'b0}};
    end
  end

  // State, step history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HALTED;
      step_q      <= 1'b0;
      sb_q        <= {N_SUB{1'b0}};
      bt_q        <= N_BITS'(1);
      ph_q        <= N_PHASES'(1);
      phase_end_q <= 1'b0;
      word_end_q  <= 1'b0;
      halted_q    <= 1'b1;
      step_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      sb_q        <= sb_d;
      bt_q        <= bt_d;
      ph_q        <= ph_d;
      phase_end_q <= phase_end_d;
      word_end_q  <= word_end_d;
      halted_q    <= halted_d;
      step_ack_q  <= step_ack_d;
    end
  end

  assign bus.sb        = sb_q;
  assign bus.bt        = bt_q;
  assign bus.ph        = ph_q;
  assign bus.phase_end = phase_end_q;
  assign bus.word_end  = word_end_q;
  assign bus.halted    = halted_q;
  assign bus.step_ack  = step_ack_q;

endmodule

// File: tb/tb_lvdc_timing_gen.sv
// Scoreboard bench for lvdc_timing_gen: a word-position model predicts every output vector.
module tb_lvdc_timing_gen;

  localparam int NS   = 4;
  localparam int NB   = 14;
  localparam int NP   = 3;
  localparam int PH_L = NS * NB;
  localparam int WORD = PH_L * NP;
  localparam int OW   = NS + NB + NP + 4;
  localparam int M_H  = 0;
  localparam int M_R  = 1;
  localparam int M_P  = 2;
  localparam int M_S  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lvdc_timing_gen_if #(.N_SUB(NS), .N_BITS(NB), .N_PHASES(NP)) bus ();

  lvdc_timing_gen #(.N_SUB(NS), .N_BITS(NB), .N_PHASES(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [OW-1:0] exp_q[$];
  int            m_pos;
  int            m_mode;
  logic          m_step_prev;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] observed();
    return {bus.sb, bus.bt, bus.ph, bus.phase_end, bus.word_end, bus.halted, bus.step_ack};
  endfunction

  // Predict the vector the DUT shows after the coming edge, then move the model across it.
  task automatic model_push(input logic r, input logic s);
    logic [NS-1:0] e_sb;
    logic [NB-1:0] e_bt;
    logic [NP-1:0] e_ph;
    logic adv, pe, we, sa;
    int nxt;
    adv  = (m_mode != M_H);
    e_sb = adv ? NS'(1 << (m_pos % NS)) : {NS{1'b0}};
    e_bt = NB'(1 << ((m_pos / NS) % NB));
    e_ph = NP'(1 << (m_pos / PH_L));
    pe   = adv && ((m_pos % PH_L) == PH_L - 1);
    we   = adv && (m_pos == WORD - 1);
    sa   = (m_mode == M_S) && pe;
    exp_q.push_back({e_sb, e_bt, e_ph, pe, we, !adv, sa});
    nxt = m_mode;
    case (m_mode)
      M_H: if (r) nxt = M_R; else if (s && !m_step_prev) nxt = M_S;
      M_R: if (!r) nxt = (m_pos == WORD - 1) ? M_H : M_P;
      M_P: if (r) nxt = M_R; else if (m_pos == WORD - 1) nxt = M_H;
      M_S: if ((m_pos % PH_L) == PH_L - 1) nxt = M_H;
      default: nxt = M_H;
    endcase
    if (adv) m_pos = (m_pos + 1) % WORD;
    m_mode      = nxt;
    m_step_prev = s;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pos       = 0;
    m_mode      = M_H;
    m_step_prev = 1'b0;
  endtask

  task automatic tick(input logic r, input logic s);
    logic [OW-1:0] e;
    @(negedge clk);
    bus.run  = r;
    bus.step = s;
    model_push(r, s);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("out", 32'(observed()), 32'(e));
  endtask

  // One step from a halted word/phase start; counts strobes and step acknowledges until halted.
  task automatic do_step(input logic hold, output int pulses, output int acks, output bit done);
    pulses = 0;
    acks   = 0;
    done   = 1'b0;
    tick(1'b0, 1'b1);
    for (int i = 0; i < 100 && !done; i++) begin
      tick(1'b0, hold);
      if (bus.sb != {NS{1'b0}}) pulses++;
      if (bus.step_ack && bus.phase_end) acks++;
      if (bus.halted && pulses > 0) done = 1'b1;
    end
  endtask

  initial begin
    int cnt, cnt2, sum, we_at, pulses, acks;
    bit done;
    bus.run  = 1'b0;
    bus.step = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_vals", 32'(observed()), 32'({4'b0000, 14'h0001, 3'b001, 1'b0, 1'b0, 1'b1, 1'b0}));
    @(negedge clk);
    rst = 1'b0;

    cnt = 0;
    repeat (50) begin
      tick(1'b0, 1'b0);
      cnt += int'(bus.phase_end) + int'(bus.word_end) + int'(bus.sb != 4'b0000);
    end
    check_eq("idle_pulses", 32'(cnt), 32'd0);

    tick(1'b1, 1'b0);
    cnt = 0; sum = 0; we_at = -1;
    for (int i = 0; i < WORD; i++) begin
      tick(1'b1, 1'b0);
      if (bus.phase_end) begin cnt++; sum += i; end
      if (bus.word_end) we_at = i;
    end
    check_eq("pe_count", 32'(cnt), 32'd3);
    check_eq("pe_idx_sum", 32'(sum), 32'd333);
    check_eq("we_idx", 32'(we_at), 32'd167);
    tick(1'b1, 1'b0);
    check_eq("wrap_bt_ph", 32'({bus.bt, bus.ph}), 32'({14'h0001, 3'b001}));

    repeat (29) tick(1'b1, 1'b0);
    cnt = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick(1'b0, 1'b0);
      if (bus.sb != 4'b0000) cnt++;
      if (bus.halted) done = 1'b1;
    end
    check_eq("drop_halt_seen", 32'(done), 32'd1);
    check_eq("drop_sb_count", 32'(cnt), 32'd138);
    repeat (31) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check_eq("resume_first", 32'({bus.sb, bus.bt, bus.ph, bus.halted}),
             32'({4'b0001, 14'h0001, 3'b001, 1'b0}));

    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick(1'b0, 1'b0);
      if (bus.halted) done = 1'b1;
    end
    check_eq("halt_for_step", 32'(done), 32'd1);
    repeat (3) tick(1'b0, 1'b0);

    do_step(1'b0, pulses, acks, done);
    check_eq("step1_done", 32'(done), 32'd1);
    check_eq("step1_sb", 32'(pulses), 32'd56);
    check_eq("step1_ack", 32'(acks), 32'd1);
    check_eq("step1_ph", 32'(bus.ph), 32'(3'b010));

    do_step(1'b1, pulses, acks, done);
    check_eq("step2_sb", 32'(pulses), 32'd56);
    check_eq("step2_ph", 32'(bus.ph), 32'(3'b100));
    cnt = 0;
    repeat (10) begin
      tick(1'b0, 1'b1);
      if (bus.sb != 4'b0000) cnt++;
    end
    check_eq("held_step", 32'(cnt), 32'd0);
    tick(1'b0, 1'b0);

    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick(1'b1, 1'b0);
      if (bus.word_end) done = 1'b1;
    end
    check_eq("sync_word", 32'(done), 32'd1);
    cnt = 0; cnt2 = 0;
    repeat (30) tick(1'b1, 1'b0);
    repeat (70) begin
      tick(1'b0, 1'b0);
      if (bus.halted) cnt++;
      if (bus.sb == 4'b0000) cnt2++;
    end
    repeat (178) begin
      tick(1'b1, 1'b0);
      if (bus.halted) cnt++;
      if (bus.sb == 4'b0000) cnt2++;
    end
    check_eq("pend_halted", 32'(cnt), 32'd0);
    check_eq("pend_sb_gap", 32'(cnt2), 32'd0);

    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick(1'b1, 1'b0);
      if (bus.ph == 3'b010 && bus.bt == 14'h0080) done = 1'b1;
    end
    check_eq("reach_mid", 32'(done), 32'd1);
    #3;
    rst      = 1'b1;
    bus.run  = 1'b0;
    bus.step = 1'b0;
    #1;
    check_eq("mid_rst", 32'({bus.sb, bus.bt, bus.ph, bus.halted}),
             32'({4'b0000, 14'h0001, 3'b001, 1'b1}));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (20) begin
      tick(1'b0, 1'b0);
      cnt += int'(bus.phase_end) + int'(bus.word_end) + int'(bus.sb != 4'b0000);
    end
    check_eq("post_rst_quiet", 32'(cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
